// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider with a start/done handshake.
// Produces one quotient bit per clock. Results are held until the next completion.
module seq_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;

  // The bit shifted out of R is kept as the top of r_ext; a set top bit
  // guarantees the trial subtract succeeds, so no extra R width is needed.
  logic [WIDTH:0]   r_ext;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] r_new;
  logic [WIDTH-1:0] q_new;

  assign r_ext = {r_q, q_q[WIDTH-1]};
  assign trial = r_ext - {1'b0, d_q};
  assign r_new = trial[WIDTH] ? r_ext[WIDTH-1:0] : trial[WIDTH-1:0];
  assign q_new = {q_q[WIDTH-2:0], ~trial[WIDTH]};

  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    q_d         = q_q;
    d_d         = d_q;
    count_d     = count_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (divisor != '0) begin
            r_d     = '0;
            q_d     = dividend;
            d_d     = divisor;
            count_d = '0;
            state_d = DIV;
          end else begin
            quotient_d  = '1;
            remainder_d = dividend;
            dbz_d       = 1'b1;
            state_d     = DONE;
          end
        end
      end
      DIV: begin
        r_d     = r_new;
        q_d     = q_new;
        count_d = count_q + CW'(1);
        if (count_q == LAST) begin
          quotient_d  = q_new;
          remainder_d = r_new;
          dbz_d       = 1'b0;
          state_d     = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      r_q         <= '0;
      q_q         <= '0;
      d_q         <= '0;
      count_q     <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      q_q         <= q_d;
      d_q         <= d_d;
      count_q     <= count_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign busy        = (state_q == DIV);
  assign done        = (state_q == DONE);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed table, handshake corner
// cases, exhaustive back-to-back sweep and random ops against a reference model.
module tb_seq_divider;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] lastQ = '0;
  logic [W-1:0] lastR = '0;
  logic         lastZ = 1'b0;

  typedef struct {
    logic [W-1:0] dvd;
    logic [W-1:0] dvs;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
  } vec_t;

  vec_t table_v[8];

  seq_divider #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .dividend(dividend),
    .divisor(divisor),
    .busy(busy),
    .done(done),
    .quotient(quotient),
    .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference behaviour: plain integer division, all-ones quotient on zero divisor.
  task automatic refDiv(input int dvd, input int dvs,
                        output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
    if (dvs == 0) begin
      q = '1;
      r = W'(dvd);
      z = 1'b1;
    end else begin
      q = W'(dvd / dvs);
      r = W'(dvd % dvs);
      z = 1'b0;
    end
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Called on a negedge with the DUT idle; returns on the negedge after the done cycle.
  task automatic applyStimulus(input logic [W-1:0] dvd, input logic [W-1:0] dvs,
                               input logic [W-1:0] expQ, input logic [W-1:0] expR,
                               input logic expZ, input bit keepStart);
    int lat;
    int busyCnt;
    int expLat;
    expLat   = (dvs == 0) ? 1 : W + 1;
    dividend = dvd;
    divisor  = dvs;
    start    = 1'b1;
    @(negedge clk);
    if (!keepStart) start = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
    lat      = 1;
    busyCnt  = 0;
    while (!done && lat < 3 * W + 10) begin
      if (busy) busyCnt++;
      if (quotient !== lastQ || remainder !== lastR || div_by_zero !== lastZ)
        checkOutput("held_results", {quotient, remainder, div_by_zero},
                    {lastQ, lastR, lastZ});
      @(negedge clk);
      lat++;
    end
    checkOutput("done_seen", done, 1);
    checkOutput("latency", lat, expLat);
    checkOutput("busy_cycles", busyCnt, expLat - 1);
    checkOutput("busy_in_done", busy, 0);
    checkOutput("quotient", quotient, expQ);
    checkOutput("remainder", remainder, expR);
    checkOutput("div_by_zero", div_by_zero, expZ);
    lastQ = expQ;
    lastR = expR;
    lastZ = expZ;
    @(negedge clk);
    checkOutput("done_single_pulse", done, 0);
  endtask

  initial begin
    logic [W-1:0] mq, mr;
    logic         mz;

    table_v[0] = '{dvd: 4'd13, dvs: 4'd3,  q: 4'd4,  r: 4'd1,  z: 1'b0};
    table_v[1] = '{dvd: 4'd15, dvs: 4'd1,  q: 4'd15, r: 4'd0,  z: 1'b0};
    table_v[2] = '{dvd: 4'd2,  dvs: 4'd9,  q: 4'd0,  r: 4'd2,  z: 1'b0};
    table_v[3] = '{dvd: 4'd7,  dvs: 4'd0,  q: 4'hF,  r: 4'd7,  z: 1'b1};
    table_v[4] = '{dvd: 4'd12, dvs: 4'd5,  q: 4'd2,  r: 4'd2,  z: 1'b0};
    table_v[5] = '{dvd: 4'd0,  dvs: 4'd7,  q: 4'd0,  r: 4'd0,  z: 1'b0};
    table_v[6] = '{dvd: 4'd15, dvs: 4'd15, q: 4'd1,  r: 4'd0,  z: 1'b0};
    table_v[7] = '{dvd: 4'd14, dvs: 4'd15, q: 4'd0,  r: 4'd14, z: 1'b0};

    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_outputs", {quotient, remainder, div_by_zero}, 0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] directed table");
    for (int i = 0; i < 8; i++)
      applyStimulus(table_v[i].dvd, table_v[i].dvs, table_v[i].q, table_v[i].r,
                    table_v[i].z, 1'b0);

    $display("[TB] start re-pulsed during DIV and DONE");
    dividend = 4'd13;
    divisor  = 4'd3;
    start    = 1'b1;
    @(negedge clk);
    dividend = 4'd9;
    divisor  = 4'd2;
    for (int i = 0; i < 3 * W && !done; i++) @(negedge clk);
    checkOutput("ignore_done_seen", done, 1);
    @(negedge clk);
    start = 1'b0;
    checkOutput("ignore_not_restarted", {busy, done}, 0);
    checkOutput("ignore_quotient", quotient, 4);
    checkOutput("ignore_remainder", remainder, 1);
    lastQ = 4'd4;
    lastR = 4'd1;
    lastZ = 1'b0;
    @(negedge clk);
    checkOutput("ignore_still_idle", {busy, done}, 0);

    $display("[TB] reset during DIV");
    dividend = 4'd12;
    divisor  = 4'd5;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checkOutput("pre_reset_busy", busy, 1);
    rst = 1'b1;
    #1;
    checkOutput("midop_reset_busy", busy, 0);
    checkOutput("midop_reset_done", done, 0);
    checkOutput("midop_reset_outputs", {quotient, remainder, div_by_zero}, 0);
    lastQ = '0;
    lastR = '0;
    lastZ = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < W + 2; i++) begin
      @(negedge clk);
      checkOutput("no_done_after_reset", {busy, done}, 0);
    end
    applyStimulus(4'd12, 4'd5, 4'd2, 4'd2, 1'b0, 1'b0);

    $display("[TB] exhaustive back-to-back sweep");
    for (int a = 0; a < (1 << W); a++) begin
      for (int b = 0; b < (1 << W); b++) begin
        refDiv(a, b, mq, mr, mz);
        applyStimulus(W'(a), W'(b), mq, mr, mz, 1'b1);
      end
    end
    start = 1'b0;
    @(negedge clk);

    $display("[TB] random ops with gaps");
    for (int n = 0; n < 40; n++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      rb = W'($urandom_range(0, (1 << W) - 1));
      refDiv(int'(ra), int'(rb), mq, mr, mz);
      applyStimulus(ra, rb, mq, mr, mz, 1'b0);
      for (int g = $urandom_range(0, 2); g > 0; g--) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
